// File: rtl/div_pkg.sv
// Shared encodings and constants for the multi-cycle divider used by the EX stage.
package div_pkg;

  localparam int DivDataW = 32;
  localparam int DivCntW  = 6;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef logic [63:0] double_reg_bus_t;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// Start/ready handshake between EX and the divider, carrying operands and the {rem, quo} result.
interface div_if #(
  parameter int DATA_W = 32
);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// Restoring divider: one quotient bit per cycle on operand magnitudes, then a
// sign fix-up so the quotient truncates toward zero and the remainder follows the dividend.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DivDataW,
  parameter int CNT_W  = DivCntW
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic              signedDiv_q;
  logic              sign1_q;
  logic              sign2_q;

  logic [DATA_W:0]   partial_d;
  logic [DATA_W+1:0] trial_d;
  logic              qBit_d;
  logic [DATA_W-1:0] stepRem_d;
  logic [DATA_W-1:0] mag1_d;
  logic [DATA_W-1:0] mag2_d;

  // The quotient bit is 1 only when the trial difference is non-negative and fits back in DATA_W bits.
  always_comb begin
    partial_d = {rem_q, dividend_q[DATA_W-1]};
    trial_d   = {1'b0, partial_d} - {2'b00, divisor_q};
    qBit_d    = (trial_d[DATA_W+1:DATA_W] == 2'b00);
    stepRem_d = qBit_d ? trial_d[DATA_W-1:0] : partial_d[DATA_W-1:0];
    mag1_d    = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2_d    = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DivFree;
      cnt_q        <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      signedDiv_q  <= 1'b0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          bus.result_o <= '0;
          bus.ready_o  <= DivResultNotReady;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q     <= DivOn;
              cnt_q       <= '0;
              dividend_q  <= mag1_d;
              divisor_q   <= mag2_d;
              rem_q       <= '0;
              quo_q       <= '0;
              signedDiv_q <= bus.signed_div_i;
              sign1_q     <= bus.opdata1_i[DATA_W-1];
              sign2_q     <= bus.opdata2_i[DATA_W-1];
            end
          end
        end
        DivByZero: begin
          bus.ready_o <= DivResultNotReady;
          if (bus.annul_i) begin
            state_q <= DivFree;
          end else begin
            rem_q   <= DATA_W'(ZeroWord);
            quo_q   <= DATA_W'(ZeroWord);
            state_q <= DivEnd;
          end
        end
        DivOn: begin
          bus.ready_o <= DivResultNotReady;
          if (bus.annul_i) begin
            state_q <= DivFree;
          end else if (cnt_q != LastCnt) begin
            rem_q      <= stepRem_d;
            quo_q      <= {quo_q[DATA_W-2:0], qBit_d};
            dividend_q <= {dividend_q[DATA_W-2:0], 1'b0};
            cnt_q      <= cnt_q + 1'b1;
          end else begin
            if (signedDiv_q && (sign1_q ^ sign2_q)) quo_q <= -quo_q;
            if (signedDiv_q && sign1_q)             rem_q <= -rem_q;
            state_q <= DivEnd;
          end
        end
        DivEnd: begin
          // Result is held for as long as EX keeps start raised.
          if (bus.annul_i || bus.start_i == DivStop) begin
            state_q      <= DivFree;
            bus.ready_o  <= DivResultNotReady;
            bus.result_o <= '0;
          end else begin
            bus.ready_o  <= DivResultReady;
            bus.result_o <= {rem_q, quo_q};
          end
        end
        default: begin
          state_q     <= DivFree;
          bus.ready_o <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule
